i2c_init_sequencer: RTL and testbench
=====================================

Name: i2c_init_sequencer

Overview:
Power-up configuration controller for the board's I2C peripheral (ECG front-end / LED driver). It holds the peripheral in reset for a fixed delay, then walks an external register-write table and issues byte-level commands to the I2C byte engine, which runs from the divided 800 kHz I2C clock domain via its own handshake. On completion it raises done and led_enable. It is the sequencer that sits between the top-level INIT/I2C flow and the I2C byte engine.

Parameters:
INIT_DELAY, 1000, clk cycles periph_rst is held high after reset release
NUM_WRITES, 8, number of table entries to execute (1..2**IDX_W)
IDX_W, 4, table index width
DEV_ADDR, 7'h48, 7-bit I2C target address
MAX_RETRY, 3, retries per entry on NACK (only with SEQ_RETRY_EN)

Ports:
clk  in  1  system clock, 24 MHz
rst  in  1  synchronous, active-low reset
start  in  1  pulse; re-runs table from entry 0 (no init delay) when in DONE or ERROR; ignored otherwise
tbl_addr  out  IDX_W  table index
tbl_data  in  16  {reg_addr[15:8], value[7:0]}, valid 1 cycle after tbl_addr
cmd_valid  out  1  command request to byte engine
cmd_ready  in  1  byte engine accepts command
cmd_op  out  2  00 WRITE, 01 START+WRITE, 10 WRITE+STOP, 11 STOP only
cmd_byte  out  8  byte to transmit (don't-care for STOP)
rsp_valid  in  1  one-cycle pulse: command finished
rsp_ack  in  1  target ACK for that byte (valid with rsp_valid)
periph_rst  out  1  peripheral reset, high during init delay
busy  out  1  high from sequence start until DONE/ERROR
done  out  1  table completed, level
error  out  1  sequence aborted, level
err_index  out  IDX_W  entry that failed
led_enable  out  1  set with done, cleared by reset or start

Behaviour:
- Reset (rst=0 at posedge): state INIT_WAIT, delay counter=INIT_DELAY, periph_rst=1, busy=1, cmd_valid=0, cmd_op=0, cmd_byte=0, tbl_addr=0, done=0, error=0, err_index=0, led_enable=0, retry count=0. Reset mid-transfer abandons the command immediately; byte engine is reset by the same rst.
- INIT_WAIT: decrement counter each cycle; at 0, periph_rst<=0 and go FETCH. periph_rst is high for exactly INIT_DELAY cycles after reset release.
- FETCH: drive tbl_addr=index; next cycle LATCH captures tbl_data into reg_addr/value.
- SEND_DEV: cmd_op=01, cmd_byte={DEV_ADDR,1'b0}. SEND_REG: op=00, byte=reg_addr. SEND_DATA: op=10, byte=value.
- Handshake: cmd_valid held high with cmd_op/cmd_byte stable until cycle where cmd_ready=1; transfer occurs that cycle; cmd_valid=0 next cycle. Then WAIT_RSP until rsp_valid. Exactly one command outstanding. rsp_valid outside WAIT_RSP is ignored.
- rsp_ack=1: advance SEND_DEV->SEND_REG->SEND_DATA; after SEND_DATA ack, index==NUM_WRITES-1 -> DONE, else index+1, retry=0, FETCH.
- rsp_ack=0 (NACK) on any byte: issue STOP (op=11), wait its rsp (ack ignored), then RETRY_DECIDE.
- DONE: done=1, led_enable=1, busy=0. ERROR: error=1, err_index=failing index, busy=0.
- start in DONE/ERROR: clear done, error, led_enable; index=0, retry=0, busy=1, go FETCH; periph_rst stays 0. start coincident with reaching DONE/ERROR is ignored (acts only from the following cycle).
- Index never wraps; no command issued after last entry.

Optional Feature:
SEQ_RETRY_EN: when defined, RETRY_DECIDE restarts the current entry at SEND_DEV if retry<MAX_RETRY (retry+1); otherwise ERROR. Entry is attempted at most MAX_RETRY+1 times. When undefined, the first NACK (after its STOP) goes straight to ERROR; retry counter and MAX_RETRY unused.

Test Plan:
- Reset, INIT_DELAY=10: periph_rst=1 for exactly 10 cycles after rst rises, no cmd_valid before FETCH.
- NUM_WRITES=2, table {16'h0180,16'h0203}, always-ACK engine: command stream (01,90),(00,01),(10,80),(01,90),(00,02),(10,03); then done=1, led_enable=1, busy=0.
- cmd_ready held low 5 cycles on second byte: cmd_valid, op, byte stable all 5 cycles; single transfer only.
- NACK on data byte of entry 1, SEQ_RETRY_EN, MAX_RETRY=3, later ACK: STOP issued, entry 1 resent from (01,90); completes with done=1.
- Persistent NACK on entry 0 device byte: with SEQ_RETRY_EN 4 attempts + 4 STOPs then error=1, err_index=0; without macro 1 attempt + STOP then error=1.
- start pulse in DONE: done/led_enable drop next cycle, sequence replays from index 0 with periph_rst=0; rst=0 mid-transfer returns all outputs to reset values.

Source files
------------

// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : i2c_init_sequencer                                              |
// | Purpose  : Power-up configuration sequencer. Holds the peripheral in reset |
// |            for INIT_DELAY cycles, then walks an external register-write    |
// |            table and issues byte commands (device address, register,      |
// |            value) to the I2C byte engine over a valid/ready handshake,     |
// |            waiting for each byte's response before issuing the next.      |
// |            A NACK is followed by a STOP, then either a retry of the entry  |
// |            or an abort.                                                    |
// | Option   : SEQ_RETRY_EN - when defined, a NACKed entry is restarted up to  |
// |            MAX_RETRY times before aborting; otherwise the first NACK       |
// |            aborts.                                                         |
// | Ports    : clk, rst (sync, active-low)                                     |
// |            start                - re-run table from DONE/ERROR             |
// |            tbl_addr/tbl_data    - table read (data one cycle after addr)  |
// |            cmd_valid/ready/op/byte - command to byte engine               |
// |            rsp_valid/rsp_ack    - per-command completion and ACK status    |
// |            periph_rst, busy, done, error, err_index, led_enable - status   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module i2c_init_sequencer #(
  parameter int         INIT_DELAY = 1000,
  parameter int         NUM_WRITES = 8,
  parameter int         IDX_W      = 4,
  parameter logic [6:0] DEV_ADDR   = 7'h48,
  parameter int         MAX_RETRY  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [IDX_W-1:0] tbl_addr,
  input  logic [15:0]      tbl_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [1:0]       cmd_op,
  output logic [7:0]       cmd_byte,
  input  logic             rsp_valid,
  input  logic             rsp_ack,
  output logic             periph_rst,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [IDX_W-1:0] err_index,
  output logic             led_enable
);

  localparam int               c_CNT_W      = (INIT_DELAY < 2) ? 1 : $clog2(INIT_DELAY + 1);
  localparam logic [IDX_W-1:0] c_LAST_IDX   = IDX_W'(NUM_WRITES - 1);

  localparam logic [1:0]       c_OP_WRITE      = 2'b00;
  localparam logic [1:0]       c_OP_START      = 2'b01;
  localparam logic [1:0]       c_OP_WRITE_STOP = 2'b10;
  localparam logic [1:0]       c_OP_STOP       = 2'b11;

  typedef enum logic [3:0] {
    S_INIT_WAIT    = 4'd0,
    S_FETCH        = 4'd1,
    S_LATCH        = 4'd2,
    S_SEND_DEV     = 4'd3,
    S_SEND_REG     = 4'd4,
    S_SEND_DATA    = 4'd5,
    S_SEND_STOP    = 4'd6,
    S_WAIT_RSP     = 4'd7,
    S_RETRY_DECIDE = 4'd8,
    S_DONE         = 4'd9,
    S_ERROR        = 4'd10
  } t_state;

  t_state             r_state;
  t_state             w_next_state;
  logic [c_CNT_W-1:0] r_delay_cnt;
  logic [IDX_W-1:0]   r_index;
  logic [7:0]         r_reg_addr;
  logic [7:0]         r_value;
  // Op of the command in flight; tells WAIT_RSP which byte just completed.
  logic [1:0]         r_last_op;

`ifdef SEQ_RETRY_EN
  localparam int               c_RTY_W   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [c_RTY_W-1:0] c_MAX_RTY = c_RTY_W'(MAX_RETRY);
  logic [c_RTY_W-1:0] r_retry;
`else
  logic w_unused_retry;
  assign w_unused_retry = (MAX_RETRY < 0);
`endif

  assign tbl_addr = r_index;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_INIT_WAIT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and command/status outputs
  always_comb begin
    w_next_state = r_state;
    cmd_valid    = 1'b0;
    cmd_op       = c_OP_WRITE;
    cmd_byte     = 8'h00;
    done         = 1'b0;
    error        = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_INIT_WAIT: begin
        if (r_delay_cnt <= c_CNT_W'(1)) w_next_state = S_FETCH;
      end
      S_FETCH: w_next_state = S_LATCH;
      S_LATCH: w_next_state = S_SEND_DEV;
      S_SEND_DEV: begin
        cmd_valid = 1'b1;
        cmd_op    = c_OP_START;
        cmd_byte  = {DEV_ADDR, 1'b0};
        if (cmd_ready) w_next_state = S_WAIT_RSP;
      end
      S_SEND_REG: begin
        cmd_valid = 1'b1;
        cmd_op    = c_OP_WRITE;
        cmd_byte  = r_reg_addr;
        if (cmd_ready) w_next_state = S_WAIT_RSP;
      end
      S_SEND_DATA: begin
        cmd_valid = 1'b1;
        cmd_op    = c_OP_WRITE_STOP;
        cmd_byte  = r_value;
        if (cmd_ready) w_next_state = S_WAIT_RSP;
      end
      S_SEND_STOP: begin
        cmd_valid = 1'b1;
        cmd_op    = c_OP_STOP;
        if (cmd_ready) w_next_state = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        if (rsp_valid) begin
          // The STOP's own ACK bit carries no meaning.
          if (r_last_op == c_OP_STOP) begin
            w_next_state = S_RETRY_DECIDE;
          end else if (!rsp_ack) begin
            w_next_state = S_SEND_STOP;
          end else begin
            case (r_last_op)
              c_OP_START: w_next_state = S_SEND_REG;
              c_OP_WRITE: w_next_state = S_SEND_DATA;
              default:    w_next_state = (r_index == c_LAST_IDX) ? S_DONE : S_FETCH;
            endcase
          end
        end
      end
      S_RETRY_DECIDE: begin
`ifdef SEQ_RETRY_EN
        w_next_state = (r_retry < c_MAX_RTY) ? S_SEND_DEV : S_ERROR;
`else
        w_next_state = S_ERROR;
`endif
      end
      S_DONE: begin
        done = 1'b1;
        busy = 1'b0;
        if (start) w_next_state = S_FETCH;
      end
      S_ERROR: begin
        error = 1'b1;
        busy  = 1'b0;
        if (start) w_next_state = S_FETCH;
      end
      default: w_next_state = S_INIT_WAIT;
    endcase
  end

  assign led_enable = done;

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_delay_cnt <= c_CNT_W'(INIT_DELAY);
      periph_rst  <= 1'b1;
      r_index     <= '0;
      r_reg_addr  <= 8'h00;
      r_value     <= 8'h00;
      r_last_op   <= 2'b00;
      err_index   <= '0;
    end else begin
      case (r_state)
        S_INIT_WAIT: begin
          if (r_delay_cnt <= c_CNT_W'(1)) periph_rst <= 1'b0;
          else                            r_delay_cnt <= r_delay_cnt - c_CNT_W'(1);
        end
        S_LATCH: begin
          r_reg_addr <= tbl_data[15:8];
          r_value    <= tbl_data[7:0];
        end
        S_SEND_DEV, S_SEND_REG, S_SEND_DATA, S_SEND_STOP: begin
          if (cmd_ready) r_last_op <= cmd_op;
        end
        S_WAIT_RSP: begin
          if (rsp_valid && rsp_ack && (r_last_op == c_OP_WRITE_STOP) &&
              (r_index != c_LAST_IDX)) begin
            r_index <= r_index + IDX_W'(1);
          end
        end
        S_DONE, S_ERROR: begin
          if (start) r_index <= '0;
        end
        default: ;
      endcase
      if ((r_state == S_RETRY_DECIDE) && (w_next_state == S_ERROR)) begin
        err_index <= r_index;
      end
    end
  end

`ifdef SEQ_RETRY_EN
  // Every path into FETCH begins a fresh entry, so the retry budget restarts there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_retry <= '0;
    end else if (w_next_state == S_FETCH) begin
      r_retry <= '0;
    end else if ((r_state == S_RETRY_DECIDE) && (r_retry < c_MAX_RTY)) begin
      r_retry <= r_retry + c_RTY_W'(1);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_i2c_init_sequencer                                           |
// | Purpose  : Self-checking bench for i2c_init_sequencer. A reference model   |
// |            expands the table and an ACK plan into the expected command     |
// |            stream; a randomized byte-engine model answers commands and a   |
// |            separate monitor checks every handshake against the queue.     |
// |            Honours SEQ_RETRY_EN the same way as the design.                |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_i2c_init_sequencer;

  localparam int         INIT_DELAY = 10;
  localparam int         NUM_WRITES = 3;
  localparam int         IDX_W      = 4;
  localparam logic [6:0] DEV_ADDR   = 7'h48;
  localparam int         MAX_RETRY  = 3;
`ifdef SEQ_RETRY_EN
  localparam bit         RETRY_EN   = 1'b1;
`else
  localparam bit         RETRY_EN   = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [IDX_W-1:0] tbl_addr;
  logic [15:0]      tbl_data = 16'h0000;
  logic             cmd_valid;
  logic             cmd_ready = 1'b0;
  logic [1:0]       cmd_op;
  logic [7:0]       cmd_byte;
  logic             rsp_valid = 1'b0;
  logic             rsp_ack = 1'b0;
  logic             periph_rst;
  logic             busy;
  logic             done;
  logic             error;
  logic [IDX_W-1:0] err_index;
  logic             led_enable;

  i2c_init_sequencer #(
    .INIT_DELAY (INIT_DELAY),
    .NUM_WRITES (NUM_WRITES),
    .IDX_W      (IDX_W),
    .DEV_ADDR   (DEV_ADDR),
    .MAX_RETRY  (MAX_RETRY)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .tbl_addr   (tbl_addr),
    .tbl_data   (tbl_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_byte   (cmd_byte),
    .rsp_valid  (rsp_valid),
    .rsp_ack    (rsp_ack),
    .periph_rst (periph_rst),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .err_index  (err_index),
    .led_enable (led_enable)
  );

  always #5 clk = ~clk;

  // Table memory: registered read, data valid one cycle after the address.
  logic [15:0] table_mem [2**IDX_W];
  always @(posedge clk) tbl_data <= table_mem[tbl_addr];

  int n_cmp = 0;
  int n_bad = 0;

  logic [9:0] exp_cmd_q [$];   // {op, byte}
  bit         exp_ack_q [$];   // ACK the engine model returns, in order
  bit         exp_done;
  int         exp_err_idx;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit pick_ack(input int mode, input int e, input int p);
    case (mode)
      0:       return 1'b1;
      1:       return ($urandom_range(0, 5) != 0);
      default: return !(e == 0 && p == 0);   // device byte of entry 0 always NACKed
    endcase
  endfunction

  // Expand the table into the byte stream an I2C register write sequence
  // must produce, including STOPs after NACKs and the retry budget.
  task automatic build_run(input int mode);
    int         e;
    int         att;
    bit         ok;
    bit         a;
    logic [7:0] b [3];
    logic [1:0] o [3];
    exp_cmd_q.delete();
    exp_ack_q.delete();
    exp_done    = 1'b1;
    exp_err_idx = 0;
    o = '{2'b01, 2'b00, 2'b10};
    e = 0;
    att = 0;
    while (e < NUM_WRITES) begin
      b[0] = {DEV_ADDR, 1'b0};
      b[1] = table_mem[e][15:8];
      b[2] = table_mem[e][7:0];
      ok = 1'b1;
      for (int p = 0; p < 3 && ok; p++) begin
        a = pick_ack(mode, e, p);
        exp_cmd_q.push_back({o[p], b[p]});
        exp_ack_q.push_back(a);
        if (!a) begin
          exp_cmd_q.push_back({2'b11, 8'h00});
          exp_ack_q.push_back(1'($urandom_range(0, 1)));
          ok = 1'b0;
        end
      end
      if (ok) begin
        e++;
        att = 0;
      end else if (RETRY_EN && att < MAX_RETRY) begin
        att++;
      end else begin
        exp_done    = 1'b0;
        exp_err_idx = e;
        break;
      end
    end
  endtask

  // Byte-engine model: random ready stalls, random response latency.
  initial begin : engine
    int  stall;
    int  lat;
    bit  pending;
    bit  cur_ack;
    stall = 0; lat = 0; pending = 0; cur_ack = 1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        pending   = 0;
        stall     = 0;
      end else begin
        rsp_valid = 1'b0;
        if (cmd_ready) begin
          // cmd_valid was high across the last edge, so a transfer happened.
          cmd_ready = 1'b0;
          pending   = 1;
          lat       = $urandom_range(0, 4);
          cur_ack   = (exp_ack_q.size() > 0) ? exp_ack_q.pop_front() : 1'b1;
          stall     = $urandom_range(0, 5);
        end else if (pending) begin
          if (lat == 0) begin
            rsp_valid = 1'b1;
            rsp_ack   = cur_ack;
            pending   = 0;
          end else begin
            lat--;
          end
        end else if (cmd_valid) begin
          if (stall > 0) stall--;
          else           cmd_ready = 1'b1;
        end
      end
    end
  end

  // Monitor: checks each handshake against the expected stream, and that a
  // stalled command is held unchanged until accepted.
  initial begin : monitor
    bit         prev_stall;
    bit         prev_xfer;
    logic [9:0] prev_ob;
    logic [9:0] e;
    prev_stall = 0; prev_xfer = 0; prev_ob = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        prev_stall = 0;
        prev_xfer  = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", cmd_valid, 1'b1);
          check("hold_op_byte", {cmd_op, cmd_byte}, prev_ob);
        end
        if (prev_xfer) check("valid_drop", cmd_valid, 1'b0);
        if (cmd_valid && cmd_ready) begin
          if (exp_cmd_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_cmd: got op=%0h byte=%0h expected none", cmd_op, cmd_byte);
          end else begin
            e = exp_cmd_q.pop_front();
            check("cmd_op", cmd_op, e[9:8]);
            if (e[9:8] != 2'b11) check("cmd_byte", cmd_byte, e[7:0]);
          end
        end
        prev_stall = cmd_valid && !cmd_ready;
        prev_xfer  = cmd_valid && cmd_ready;
        prev_ob    = {cmd_op, cmd_byte};
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_periph_rst", periph_rst, 1'b1);
    check("rst_busy", busy, 1'b1);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd_op", cmd_op, 2'b00);
    check("rst_cmd_byte", cmd_byte, 8'h00);
    check("rst_tbl_addr", tbl_addr, '0);
    check("rst_done", done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_index", err_index, '0);
    check("rst_led_enable", led_enable, 1'b0);
  endtask

  task automatic wait_run();
    int t;
    t = 0;
    while (!((done || error) && exp_cmd_q.size() == 0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout: got %0d pending commands expected completion", exp_cmd_q.size());
    end
    repeat (20) @(negedge clk);   // any stray command after the end is caught
    check("end_done", done, exp_done);
    check("end_error", error, !exp_done);
    check("end_led_enable", led_enable, exp_done);
    check("end_busy", busy, 1'b0);
    check("end_periph_rst", periph_rst, 1'b0);
    if (!exp_done) check("end_err_index", err_index, exp_err_idx);
  endtask

  task automatic randomize_table();
    for (int i = 0; i < NUM_WRITES; i++) table_mem[i] = 16'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin : main
    int cnt;
    int mode;
    int t;
    for (int i = 0; i < 2**IDX_W; i++) table_mem[i] = 16'h0000;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();

    // Power-up run: fixed table, every byte ACKed
    table_mem[0] = 16'h0180;
    table_mem[1] = 16'h0203;
    table_mem[2] = 16'h7F55;
    build_run(0);
    rst = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100 && periph_rst; k++) begin
      cnt++;
      check("no_cmd_in_init", cmd_valid, 1'b0);
      @(negedge clk);
    end
    check("periph_rst_cycles", cnt, INIT_DELAY);
    wait_run();

    // Re-runs from DONE/ERROR with random tables and ACK plans
    for (int r = 1; r <= 8; r++) begin
      randomize_table();
      mode = (r == 5) ? 2 : ((r <= 2) ? 0 : 1);
      build_run(mode);
      pulse_start();
      check("start_done_clr", done, 1'b0);
      check("start_led_clr", led_enable, 1'b0);
      check("start_error_clr", error, 1'b0);
      check("start_busy", busy, 1'b1);
      check("start_periph_rst", periph_rst, 1'b0);
      if (r == 1) begin
        // A start while the sequence is running must be ignored.
        repeat (8) @(negedge clk);
        pulse_start();
      end
      wait_run();
    end

    // Reset in the middle of a command
    randomize_table();
    build_run(0);
    pulse_start();
    t = 0;
    while (!cmd_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("mid_cmd_seen", cmd_valid, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs();
    @(negedge clk);
    build_run(0);
    rst = 1'b1;
    wait_run();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
